// File: rtl/xillybus_stream_pkg.sv
// Shared types and constants for the xillybus stream multiplexer.
// Header layout constants only matter when XSTREAM_HDR_EN is defined.
package xillybus_stream_pkg;

`ifdef XSTREAM_HDR_EN
    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_BURST, ST_TAIL} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_TAIL} state_t;
`endif

    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    // Field positions in the header word, counted down from the MSB.
    localparam int HDR_MAGIC_OFS = 0;
    localparam int HDR_SEQ_OFS   = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/xillybus_stream_fifo.sv
// Synchronous standard-read FIFO of tagged words: pop_data is registered and
// valid the cycle after an accepted pop. flush empties it in one cycle.
module xillybus_stream_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pop_data <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                pop_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/xillybus_stream_mux.sv
// Round-robin merge of NCH source FIFOs into one tagged read stream with eof
// aggregation. Define XSTREAM_HDR_EN to prefix every burst with a header word.
//
// state  | meaning
// IDLE   | search for next channel after rr_ptr with enable & ~done & ~empty
// HDR    | push header word for granted channel (XSTREAM_HDR_EN only)
// BURST  | read granted channel up to MAX_BURST words, gated by FIFO credit
// TAIL   | let the last in-flight word land before re-arbitrating
module xillybus_stream_mux
    import xillybus_stream_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int DW        = 32,
    parameter int MAX_BURST = 16,
    parameter int DEPTH     = 4,
    localparam int CHW = clog2(NCH),
    localparam int BCW = clog2(MAX_BURST + 1),
    localparam int CW  = clog2(DEPTH + 1)
) (
    input  logic              bus_clk_w,
    input  logic              bus_rst_w,
    input  logic [NCH-1:0]    ch_enable_w,
    input  logic [NCH*DW-1:0] src_data_w,
    input  logic [NCH-1:0]    src_empty_w,
    input  logic [NCH-1:0]    src_eof_w,
    output logic [NCH-1:0]    src_rden_w,
    output logic [NCH-1:0]    src_open_w,
    input  logic              out_open_w,
    input  logic              out_rden_w,
    output logic [DW-1:0]     out_data_w,
    output logic [CHW-1:0]    out_chan_w,
    output logic              out_empty_w,
    output logic              out_eof_w
);

    state_t            state;
    logic [CHW-1:0]    gnt;
    logic [CHW-1:0]    rr_ptr;
    logic [CHW-1:0]    next_ch;
    logic [CHW-1:0]    cidx;
    logic              found;
    logic [BCW-1:0]    burst_cnt;
    logic [NCH-1:0]    done;
    logic              inflight;
    logic [CHW-1:0]    inflight_ch;
    logic [CW-1:0]     fifo_count;
    logic              credit;
    logic              rd_ok;
    logic              fifo_push;
    logic [DW+CHW-1:0] fifo_wdata;
    logic [DW+CHW-1:0] fifo_rdata;
    logic [DW-1:0]     src_word [NCH];

`ifdef XSTREAM_HDR_EN
    logic [7:0]    seq;
    logic [DW-1:0] hdr_word;

    always_comb begin
        hdr_word = '0;
        hdr_word[DW-1-HDR_MAGIC_OFS -: 8] = HDR_MAGIC;
        hdr_word[DW-1-HDR_SEQ_OFS -: 8]   = seq;
        hdr_word[CHW-1:0]                 = gnt;
    end
`endif

    always_comb begin
        for (int i = 0; i < NCH; i++) src_word[i] = src_data_w[i*DW +: DW];
    end

    // Words already requested from a source still need a FIFO slot.
    assign credit = (int'(fifo_count) + int'(inflight)) < DEPTH;

    assign rd_ok = out_open_w && !bus_rst_w && (state == ST_BURST) &&
                   ch_enable_w[gnt] && !src_empty_w[gnt] &&
                   (burst_cnt < BCW'(MAX_BURST)) && credit;

    always_comb begin
        src_rden_w      = '0;
        src_rden_w[gnt] = rd_ok;
    end

    always_comb begin
        found   = 1'b0;
        next_ch = '0;
        cidx    = '0;
        for (int k = 1; k <= NCH; k++) begin
            cidx = CHW'((int'(rr_ptr) + k) % NCH);
            if (!found && ch_enable_w[cidx] && !done[cidx] && !src_empty_w[cidx]) begin
                found   = 1'b1;
                next_ch = cidx;
            end
        end
    end

    always_comb begin
        fifo_push  = 1'b0;
        fifo_wdata = '0;
        if (inflight) begin
            fifo_push  = out_open_w;
            fifo_wdata = {inflight_ch, src_word[inflight_ch]};
        end
`ifdef XSTREAM_HDR_EN
        else if (state == ST_HDR && credit) begin
            fifo_push  = out_open_w;
            fifo_wdata = {gnt, hdr_word};
        end
`endif
    end

    always_ff @(posedge bus_clk_w) begin
        if (bus_rst_w) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            rr_ptr      <= CHW'(NCH - 1);
            burst_cnt   <= '0;
            done        <= '0;
            inflight    <= 1'b0;
            inflight_ch <= '0;
            src_open_w  <= '0;
            out_eof_w   <= 1'b0;
`ifdef XSTREAM_HDR_EN
            seq         <= '0;
`endif
        end else begin
            src_open_w <= {NCH{out_open_w}} & ch_enable_w;
            if (!out_open_w) begin
                state     <= ST_IDLE;
                done      <= '0;
                inflight  <= 1'b0;
                burst_cnt <= '0;
                out_eof_w <= 1'b0;
            end else begin
                inflight    <= rd_ok;
                inflight_ch <= gnt;
                done        <= done | (src_empty_w & src_eof_w);
                out_eof_w   <= (&(done | ~ch_enable_w)) && (fifo_count == '0) && !inflight;
                if (rd_ok) burst_cnt <= burst_cnt + 1'b1;
                case (state)
                    ST_IDLE: begin
                        if (found) begin
                            gnt       <= next_ch;
                            rr_ptr    <= next_ch;
                            burst_cnt <= '0;
`ifdef XSTREAM_HDR_EN
                            state     <= ST_HDR;
`else
                            state     <= ST_BURST;
`endif
                        end
                    end
`ifdef XSTREAM_HDR_EN
                    ST_HDR: begin
                        if (credit) begin
                            seq   <= seq + 1'b1;
                            state <= ST_BURST;
                        end
                    end
`endif
                    ST_BURST: begin
                        // A disabled channel ends its burst exactly like an empty one.
                        if (burst_cnt == BCW'(MAX_BURST) || src_empty_w[gnt] || !ch_enable_w[gnt])
                            state <= ST_TAIL;
                    end
                    ST_TAIL:  state <= ST_IDLE;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

    xillybus_stream_fifo #(
        .WIDTH (DW + CHW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (bus_clk_w),
        .rst       (bus_rst_w),
        .flush     (!out_open_w),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (out_rden_w),
        .pop_data  (fifo_rdata),
        .empty     (out_empty_w),
        .count     (fifo_count)
    );

    assign out_data_w = fifo_rdata[DW-1:0];
    assign out_chan_w = fifo_rdata[DW+CHW-1:DW];

endmodule

// File: tb/tb_xillybus_stream_mux.sv
// Scoreboard bench for xillybus_stream_mux; source FIFOs modelled as word memories.
// Honours XSTREAM_HDR_EN to expect burst header words.
`timescale 1ns/1ps
module tb_xillybus_stream_mux;
    import xillybus_stream_pkg::*;

    localparam int NCH  = 4;
    localparam int DW   = 32;
    localparam int CHW  = 2;
    localparam int MEMD = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    ch_enable = 4'b1111;
    logic [NCH*DW-1:0] src_data = '0;
    logic [NCH-1:0]    src_empty = '1;
    logic [NCH-1:0]    src_eof = '0;
    logic [NCH-1:0]    src_rden;
    logic [NCH-1:0]    src_open;
    logic              out_open = 1'b1;
    logic              out_rden = 1'b0;
    logic [DW-1:0]     out_data;
    logic [CHW-1:0]    out_chan;
    logic              out_empty;
    logic              out_eof;

    int vec_cnt = 0;
    int err_cnt = 0;
    int tb_seq  = 0;
    logic [DW-1:0]     smem [NCH][MEMD];
    int                wp [NCH];
    int                rp [NCH];
    logic [DW+CHW-1:0] exp_q [$];
    logic              pend = 1'b0;
    logic              sb_off = 1'b0;
    logic [63:0]       mon_exp;

    xillybus_stream_mux dut (
        .bus_clk_w   (clk),
        .bus_rst_w   (rst),
        .ch_enable_w (ch_enable),
        .src_data_w  (src_data),
        .src_empty_w (src_empty),
        .src_eof_w   (src_eof),
        .src_rden_w  (src_rden),
        .src_open_w  (src_open),
        .out_open_w  (out_open),
        .out_rden_w  (out_rden),
        .out_data_w  (out_data),
        .out_chan_w  (out_chan),
        .out_empty_w (out_empty),
        .out_eof_w   (out_eof)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkw(input int ch, input int k, input int tag);
        return {8'(tag), 8'(ch), 16'(k)};
    endfunction

    // Source FIFO model: data valid the cycle after a read strobe.
    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (src_rden[i] && rp[i] != wp[i]) begin
                src_data[i*DW +: DW] <= smem[i][rp[i]];
                rp[i]        <= rp[i] + 1;
                src_empty[i] <= (rp[i] + 1 == wp[i]);
            end else begin
                src_empty[i] <= (rp[i] == wp[i]);
            end
        end
    end

    always @(posedge clk) pend <= out_rden && !out_empty && !rst;

    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++)
            if (src_rden[i] && rp[i] == wp[i]) chk("src_underflow", 64'(i), 64'(-1));
        if (pend && !sb_off) begin
            mon_exp = 'x;
            if (exp_q.size() != 0) mon_exp = 64'(exp_q.pop_front());
            chk("out_word", 64'({out_chan, out_data}), mon_exp);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int ch, input int k0, input int n, input int tag);
        for (int k = 0; k < n; k++) begin
            smem[ch][wp[ch]] = mkw(ch, k0 + k, tag);
            wp[ch] = wp[ch] + 1;
        end
    endtask

    task automatic exp_hdr(input int ch);
`ifdef XSTREAM_HDR_EN
        exp_q.push_back({CHW'(ch), 8'hA5, 8'(tb_seq), 14'd0, CHW'(ch)});
        tb_seq = (tb_seq + 1) % 256;
`else
        tb_seq = tb_seq + ch * 0;
`endif
    endtask

    task automatic exp_run(input int ch, input int tag, input int k0, input int n);
        exp_hdr(ch);
        for (int k = 0; k < n; k++) exp_q.push_back({CHW'(ch), mkw(ch, k0 + k, tag)});
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || !out_empty) && c < maxc) begin
            tick();
            c++;
        end
        tick(2);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int c;
        int r1;
        int r3;
        int k1;
        logic eof_seen;

        // Reset values
        tick(3);
        chk("rst_rden", 64'(src_rden), 64'd0);
        chk("rst_open", 64'(src_open), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_chan", 64'(out_chan), 64'd0);
        chk("rst_empty", 64'(out_empty), 64'd1);
        chk("rst_eof", 64'(out_eof), 64'd0);
        rst = 1'b0;
        tick(2);

        // Four full channels, fixed-quantum round-robin
        out_rden = 1'b1;
        for (int ch = 0; ch < NCH; ch++) load(ch, 0, 40, 1);
        for (int r = 0; r < 3; r++)
            for (int ch = 0; ch < NCH; ch++) exp_run(ch, 1, r * 16, (r < 2) ? 16 : 8);
        wait_drain("t1_drain", 2000);

        // Only ch2 has five words
        load(2, 0, 5, 2);
        exp_run(2, 2, 0, 5);
        c = 0;
        while (rp[2] != wp[2] && c < 50) begin tick(); c++; end
        chk("t2_reads", 64'(wp[2] - rp[2]), 64'd0);
        c = 0;
        while (dut.state != ST_IDLE && c < 4) begin tick(); c++; end
        chk("t2_idle", 64'(dut.state), 64'(ST_IDLE));
        chk("t2_rden", 64'(src_rden), 64'd0);
        wait_drain("t2_drain", 200);

        // Upstream stall: FIFO fills, no overflow
        load(1, 0, 30, 3);
        exp_run(1, 3, 0, 16);
        exp_run(1, 3, 16, 14);
        tick(6);
        out_rden = 1'b0;
        tick(20);
        chk("t3_count", 64'(dut.u_fifo.count), 64'd4);
        chk("t3_rden", 64'(src_rden), 64'd0);
        chk("t3_empty", 64'(out_empty), 64'd0);
        out_rden = 1'b1;
        wait_drain("t3_drain", 500);

        // eof aggregation over enabled channels 0..2
        ch_enable = 4'b0111;
        out_rden  = 1'b0;
        load(0, 0, 3, 4);
        exp_run(0, 4, 0, 3);
        tick(3);
        src_eof  = 4'b0111;
        eof_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); eof_seen |= out_eof; end
        chk("t4_eof_early", 64'(eof_seen), 64'd0);
        out_rden = 1'b1;
        c = 0;
        while (!out_eof && c < 20) begin tick(); c++; end
        chk("t4_eof", 64'(out_eof), 64'd1);
        chk("t4_sb", 64'(exp_q.size()), 64'd0);
        chk("t4_empty", 64'(out_empty), 64'd1);
        chk("t4_open", 64'(src_open), 64'b0111);
        r3 = rp[3];
        load(3, 0, 2, 5);
        exp_run(3, 5, 0, 2);
        tick(10);
        chk("t4_ch3_skip", 64'(rp[3] - r3), 64'd0);
        chk("t4_eof_hold", 64'(out_eof), 64'd1);
        out_open = 1'b0;
        tick(2);
        chk("t4_eof_close", 64'(out_eof), 64'd0);
        chk("t4_open_close", 64'(src_open), 64'd0);
        src_eof = '0;
        tick();
        out_open  = 1'b1;
        ch_enable = 4'b1111;
        wait_drain("t4_drain", 300);

        // Reset in the middle of a ch1 burst
        sb_off = 1'b1;
        r1 = rp[1];
        load(1, 0, 20, 6);
        c = 0;
        while (rp[1] - r1 < 7 && c < 100) begin tick(); c++; end
        chk("t5_reach7", 64'(rp[1] - r1 >= 7), 64'd1);
        rst = 1'b1;
        tick();
        chk("t5_rden", 64'(src_rden), 64'd0);
        chk("t5_open", 64'(src_open), 64'd0);
        chk("t5_data", 64'(out_data), 64'd0);
        chk("t5_chan", 64'(out_chan), 64'd0);
        chk("t5_empty", 64'(out_empty), 64'd1);
        chk("t5_eof", 64'(out_eof), 64'd0);
        load(0, 0, 4, 7);
        tick();
        rst = 1'b0;
        tb_seq = 0;
        k1 = rp[1] - r1;
        exp_run(0, 7, 0, 4);
        exp_run(1, 6, k1, 20 - k1);
        sb_off = 1'b0;
        c = 0;
        while (src_rden == '0 && c < 20) begin tick(); c++; end
        chk("t5_first", 64'(src_rden), 64'b0001);
        wait_drain("t5_drain", 300);

        // Many single-word bursts (header sequence wraps when enabled)
        for (int i = 0; i < 300; i++) begin
            load(0, i, 1, 8);
            exp_run(0, 8, i, 1);
            tick(10);
        end
        wait_drain("t6_drain", 200);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
